// File: rtl/instr_encoder_pkg.sv
// Shared LEGv8 encoder constants: mnemonic codes, opcode fields and instruction formats.
package instr_encoder_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_ORR    = 4'd3;
    localparam logic [3:0] OP_LDUR   = 4'd4;
    localparam logic [3:0] OP_LDURB  = 4'd5;
    localparam logic [3:0] OP_LDURH  = 4'd6;
    localparam logic [3:0] OP_LDURSW = 4'd7;
    localparam logic [3:0] OP_STUR   = 4'd8;
    localparam logic [3:0] OP_CBZ    = 4'd9;
    localparam logic [3:0] OP_CBNZ   = 4'd10;
    localparam logic [3:0] OP_B      = 4'd11;

    // Same bit patterns the decoder's casex table matches on.
    localparam logic [10:0] OPC_ADD    = 11'b10001011000;
    localparam logic [10:0] OPC_SUB    = 11'b11001011000;
    localparam logic [10:0] OPC_AND    = 11'b10001010000;
    localparam logic [10:0] OPC_ORR    = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR   = 11'b11111000010;
    localparam logic [10:0] OPC_LDURB  = 11'b00111000010;
    localparam logic [10:0] OPC_LDURH  = 11'b01111000010;
    localparam logic [10:0] OPC_LDURSW = 11'b10111000100;
    localparam logic [10:0] OPC_STUR   = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ    = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ   = 8'b10110101;
    localparam logic [5:0]  OPC_B      = 6'b000101;

    typedef enum logic [1:0] {
        FMT_R  = 2'd0,
        FMT_D  = 2'd1,
        FMT_CB = 2'd2,
        FMT_B  = 2'd3
    } fmt_e;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer (instr_pack): mnemonic plus fields -> {word, format, op legal}.
// Immediate range checking is left to the caller, which knows the format.
module instr_encoder_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic [1:0]  fmt,
    output logic        legal
);

    logic [10:0] opc11;
    logic [7:0]  opc8;
    fmt_e        fmt_sel;

    always_comb begin
        opc11   = '0;
        opc8    = '0;
        fmt_sel = FMT_R;
        legal   = 1'b1;
        case (op)
            OP_ADD:    opc11 = OPC_ADD;
            OP_SUB:    opc11 = OPC_SUB;
            OP_AND:    opc11 = OPC_AND;
            OP_ORR:    opc11 = OPC_ORR;
            OP_LDUR:   begin fmt_sel = FMT_D;  opc11 = OPC_LDUR;   end
            OP_LDURB:  begin fmt_sel = FMT_D;  opc11 = OPC_LDURB;  end
            OP_LDURH:  begin fmt_sel = FMT_D;  opc11 = OPC_LDURH;  end
            OP_LDURSW: begin fmt_sel = FMT_D;  opc11 = OPC_LDURSW; end
            OP_STUR:   begin fmt_sel = FMT_D;  opc11 = OPC_STUR;   end
            OP_CBZ:    begin fmt_sel = FMT_CB; opc8  = OPC_CBZ;    end
            OP_CBNZ:   begin fmt_sel = FMT_CB; opc8  = OPC_CBNZ;   end
            OP_B:      fmt_sel = FMT_B;
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        word = '0;
        case (fmt_sel)
            FMT_R:   word = {opc11, rm, 6'd0, rn, rd};
            FMT_D:   word = {opc11, imm[8:0], 2'b00, rn, rd};
            FMT_CB:  word = {opc8, imm[18:0], rd};
            FMT_B:   word = {OPC_B, imm};
            default: word = '0;
        endcase
    end

    assign fmt = fmt_sel;

endmodule

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: accepts symbolic instructions and writes packed words to imem.
// Optional READBACK_CHECK_EN adds READ/CHECK states that verify each word after writing.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic              err,
    output logic              full,
    output logic [ADDR_W:0]   wr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENCODE = 3'd1,
        S_WRITE  = 3'd2,
        S_READ   = 3'd3,
        S_CHECK  = 3'd4
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_e            state;
    logic [3:0]        op_q;
    logic [4:0]        rd_q;
    logic [4:0]        rn_q;
    logic [4:0]        rm_q;
    logic [25:0]       imm_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr;

    logic [31:0]       pack_word;
    logic [1:0]        pack_fmt;
    logic              pack_legal;
    logic              d_fit;
    logic              cb_fit;
    logic              range_ok;
    logic [ADDR_W:0]   wr_count_inc;
    logic              reaches_depth;

    instr_encoder_pack u_pack (
        .op    (op_q),
        .rd    (rd_q),
        .rn    (rn_q),
        .rm    (rm_q),
        .imm   (imm_q),
        .word  (pack_word),
        .fmt   (pack_fmt),
        .legal (pack_legal)
    );

    // Upper immediate bits must all match the sign bit of the field being encoded.
    assign d_fit    = (&imm_q[25:8])  | ~(|imm_q[25:8]);
    assign cb_fit   = (&imm_q[25:18]) | ~(|imm_q[25:18]);
    assign range_ok = (pack_fmt == FMT_D)  ? d_fit  :
                      (pack_fmt == FMT_CB) ? cb_fit : 1'b1;

    assign wr_count_inc  = wr_count + 1'b1;
    assign reaches_depth = (wr_count_inc == DEPTH_W);

    assign in_ready  = (state == S_IDLE) && !full && !clr;
    assign imem_we   = we_q && !clr;
    assign imem_addr = addr;

`ifndef READBACK_CHECK_EN
    logic unused_rdata;
    assign unused_rdata = ^imem_rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            imm_q      <= '0;
            we_q       <= 1'b0;
            addr       <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            full       <= 1'b0;
            wr_count   <= '0;
        end else if (clr) begin
            state    <= S_IDLE;
            we_q     <= 1'b0;
            addr     <= '0;
            err      <= 1'b0;
            full     <= 1'b0;
            wr_count <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q  <= in_op;
                        rd_q  <= in_rd;
                        rn_q  <= in_rn;
                        rm_q  <= in_rm;
                        imm_q <= in_imm;
                        state <= S_ENCODE;
                    end
                end
                S_ENCODE: begin
                    if (pack_legal && range_ok) begin
                        imem_wdata <= pack_word;
                        we_q       <= 1'b1;
                        state      <= S_WRITE;
                    end else begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
`ifdef READBACK_CHECK_EN
                S_WRITE: begin
                    we_q  <= 1'b0;
                    state <= S_READ;
                end
                S_READ: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    err      <= (imem_rdata != imem_wdata);
                    wr_count <= wr_count_inc;
                    full     <= reaches_depth;
                    if (!reaches_depth) begin
                        addr <= addr + 1'b1;
                    end
                    state    <= S_IDLE;
                end
`else
                // The address saturates on the last slot; full then blocks further writes.
                S_WRITE: begin
                    we_q     <= 1'b0;
                    wr_count <= wr_count_inc;
                    full     <= reaches_depth;
                    if (!reaches_depth) begin
                        addr <= addr + 1'b1;
                    end
                    state    <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder built with DEPTH=4 so the full/clr path is reachable.
module tb_instr_encoder;

    typedef struct {
        logic        is_err;
        logic [7:0]  addr;
        logic [31:0] word;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [25:0] in_imm;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        err;
    logic        full;
    logic [8:0]  wr_count;

    logic [31:0] mem [0:255];
    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    int          cyc;
    logic [7:0]  exp_addr;

    instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rn      (in_rn),
        .in_rm      (in_rm),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_rdata (imem_rdata),
        .err        (err),
        .full       (full),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Simple instruction memory so readback builds see the word that was written.
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
    end
    assign imem_rdata = mem[imem_addr];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe or err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (imem_we || err)) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_event", {62'd0, imem_we, err}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("event_cycle", cyc, e.cyc);
                if (e.is_err) begin
                    checkOutput("err_pulse", err, 1'b1);
                    checkOutput("err_no_write", imem_we, 1'b0);
                    checkOutput("err_addr_hold", imem_addr, e.addr);
                end else begin
                    checkOutput("write_strobe", imem_we, 1'b1);
                    checkOutput("write_no_err", err, 1'b0);
                    checkOutput("write_addr", imem_addr, e.addr);
                    checkOutput("write_data", imem_wdata, e.word);
                end
            end
        end
    end

    task automatic waitReady();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", in_ready, 1'b1);
    endtask

    task automatic driveFields(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                               input logic [4:0] rm, input logic [25:0] imm);
        in_op    = op;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                 input logic [4:0] rm, input logic [25:0] imm,
                                 input logic is_err, input logic [31:0] word);
        exp_t e;
        waitReady();
        if (in_ready) begin
            driveFields(op, rd, rn, rm, imm);
            e.is_err = is_err;
            e.addr   = exp_addr;
            e.word   = word;
            e.cyc    = cyc + 1;
            sb.push_back(e);
            if (!is_err) exp_addr++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        exp_addr    = 8'd0;
        rst_n       = 1'b0;
        clr         = 1'b0;
        in_valid    = 1'b0;
        in_op       = '0;
        in_rd       = '0;
        in_rn       = '0;
        in_rm       = '0;
        in_imm      = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_ready", in_ready, 1'b1);
        checkOutput("rst_we", imem_we, 1'b0);
        checkOutput("rst_addr", imem_addr, 8'd0);
        checkOutput("rst_wdata", imem_wdata, 32'd0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_full", full, 1'b0);
        checkOutput("rst_count", wr_count, 9'd0);
        rst_n = 1'b1;

        applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h8B030041);
        repeat (3) @(negedge clk);
        checkOutput("add_count", wr_count, 9'd1);

        applyStimulus(4'd4, 5'd5, 5'd6, 5'd0, 26'd8, 1'b0, 32'hF84080C5);
        applyStimulus(4'd9, 5'd9, 5'd0, 5'd0, 26'h3FFFFFE, 1'b0, 32'hB4FFFFC9);
        applyStimulus(4'd4, 5'd1, 5'd2, 5'd0, 26'd256, 1'b1, 32'd0);
        applyStimulus(4'd13, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("after_err_count", wr_count, 9'd3);
        checkOutput("after_err_addr", imem_addr, 8'd3);
        checkOutput("after_err_full", full, 1'b0);

        applyStimulus(4'd11, 5'd0, 5'd0, 5'd0, 26'd4, 1'b0, 32'h14000004);
        repeat (4) @(negedge clk);
        checkOutput("full_flag", full, 1'b1);
        checkOutput("full_ready", in_ready, 1'b0);
        checkOutput("full_count", wr_count, 9'd4);
        checkOutput("full_addr_nowrap", imem_addr, 8'd3);

        in_op    = 4'd1;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("full_blocks", in_ready, 1'b0);
        end
        in_valid = 1'b0;

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_addr = 8'd0;
        checkOutput("clr_full", full, 1'b0);
        checkOutput("clr_count", wr_count, 9'd0);
        checkOutput("clr_addr", imem_addr, 8'd0);

        applyStimulus(4'd1, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0, 32'hCB0600A4);
        applyStimulus(4'd2, 5'd7, 5'd8, 5'd9, 26'd0, 1'b0, 32'h8A090107);
        repeat (3) @(negedge clk);
        checkOutput("pre_clr_count", wr_count, 9'd2);

        // ORR accepted, then clr lands in its WRITE cycle: the strobe must be suppressed.
        waitReady();
        driveFields(4'd3, 5'd1, 5'd2, 5'd3, 26'd0);
        @(posedge clk);
        #1 clr = 1'b1;
        #1 checkOutput("clr_write_we", imem_we, 1'b0);
        @(posedge clk);
        #1 clr = 1'b0;
        exp_addr = 8'd0;
        checkOutput("clr_write_count", wr_count, 9'd0);
        checkOutput("clr_write_addr", imem_addr, 8'd0);

        applyStimulus(4'd1, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0, 32'hCB0600A4);
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_count", wr_count, 9'd1);

        waitReady();
        driveFields(4'd8, 5'd1, 5'd2, 5'd0, 26'h3FFFFF8);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_we", imem_we, 1'b0);
        checkOutput("arst_addr", imem_addr, 8'd0);
        checkOutput("arst_wdata", imem_wdata, 32'd0);
        checkOutput("arst_err", err, 1'b0);
        checkOutput("arst_full", full, 1'b0);
        checkOutput("arst_count", wr_count, 9'd0);
        checkOutput("arst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr = 8'd0;

        applyStimulus(4'd8, 5'd1, 5'd2, 5'd0, 26'h3FFFFF8, 1'b0, 32'hF81F8041);
        applyStimulus(4'd10, 5'd3, 5'd0, 5'd0, 26'd262143, 1'b0, 32'hB57FFFE3);
        applyStimulus(4'd9, 5'd3, 5'd0, 5'd0, 26'd262144, 1'b1, 32'd0);
        applyStimulus(4'd5, 5'd0, 5'd0, 5'd0, 26'h3FFFF00, 1'b0, 32'h38500000);
        applyStimulus(4'd4, 5'd0, 5'd0, 5'd0, 26'h3FFFEFF, 1'b1, 32'd0);
        applyStimulus(4'd11, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b0, 32'h17FFFFFF);
        repeat (8) @(negedge clk);
        checkOutput("end_full", full, 1'b1);
        checkOutput("end_count", wr_count, 9'd4);
        checkOutput("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the LEGv8 control/opcode decode path.
- Accepts symbolic instructions (mnemonic code plus register and immediate fields) over a valid/ready handshake.
- Packs each into a 32-bit LEGv8 machine word and writes it to instruction memory at an auto-incrementing address.
- Used by the bench/boot loader to fill instruction memory before the core runs.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- DEPTH, 256, number of words that may be written before full (DEPTH ≤ 2^ADDR_W).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: abort current op, address to 0.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept.
- in_op  in  4  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 LDURB, 6 LDURH, 7 LDURSW, 8 STUR, 9 CBZ, 10 CBNZ, 11 B, 12-15 illegal.
- in_rd  in  5  Rd/Rt.
- in_rn  in  5  Rn.
- in_rm  in  5  Rm (R-format only).
- in_imm  in  26  signed immediate (D: address, CB: imm19, B: imm26).
- imem_we  out  1  write strobe, one cycle.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- imem_rdata  in  32  read data, used only with the optional feature.
- err  out  1  one-cycle pulse: illegal op or immediate out of range.
- full  out  1  DEPTH words written.
- wr_count  out  ADDR_W+1  words written since reset/clr.

Behaviour:
- Reset values:
  - State IDLE.
  - imem_we=0, imem_addr=0, imem_wdata=0, err=0, full=0, wr_count=0.
  - in_ready=1.
- FSM IDLE -> ENCODE -> WRITE -> IDLE.
- in_ready = (state==IDLE) && !full && !clr.
- Acceptance: in_valid && in_ready on cycle N latches all fields.
- ENCODE (cycle N+1): builds the word into a register and range-checks the immediate.
- WRITE (cycle N+2): imem_we=1, imem_addr=current address, imem_wdata=word. Address and wr_count increment at the end of the cycle.
- Back to IDLE at N+3; throughput is one instruction per 3 cycles.
- Encodings:
  - R-format: [31:21] opcode (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000), [20:16] Rm, [15:10] shamt=0, [9:5] Rn, [4:0] Rd.
  - D-format: [31:21] opcode (LDUR 11111000010, LDURB 00111000010, LDURH 01111000010, LDURSW 10111000100, STUR 11111000000), [20:12] address = in_imm[8:0], [11:10] = 00, [9:5] Rn, [4:0] Rt.
  - CB-format: [31:24] opcode (CBZ 10110100, CBNZ 10110101), [23:5] in_imm[18:0], [4:0] Rt.
  - B-format: [31:26] 000101, [25:0] in_imm.
- Range checks, applied to the sign-extended value:
  - D-format: -256..255.
  - CB-format: -2^18..2^18-1.
  - B-format: always legal.
- Error path: an illegal op or out-of-range immediate in ENCODE pulses err in the following cycle. In that case there is no WRITE, the address and wr_count are unchanged, and the FSM returns to IDLE.
- full asserts when wr_count==DEPTH. It stays set until clr or reset, and in_ready is held low while it is set.
- The address does not wrap; full blocks any further writes.
- clr has priority in any state:
  - Next state IDLE.
  - Address and wr_count go to 0; full clears.
  - Any pending write is dropped: imem_we=0 on the clr cycle even in WRITE.
- in_valid while in_ready=0: no acceptance; fields are ignored.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: READBACK_CHECK_EN.
- When defined: WRITE -> READ -> CHECK -> IDLE.
  - READ drives imem_addr to the just-written address with imem_we=0.
  - CHECK compares imem_rdata to the word; a mismatch pulses err.
  - Throughput becomes one instruction per 5 cycles.
  - The address and wr_count increment after CHECK, whether or not the check matched.
- When undefined: no READ/CHECK states and imem_rdata is unused.

Decomposition:
- Shared package/header constants.vh:
  - in_op mnemonic codes.
  - 11-bit R/D opcodes, 8-bit CB opcodes, 6-bit B opcode (the same values the decoder's casex patterns match).
  - Format enum R/D/CB/B.
- Sub-module: instr_pack, a combinational packer from op and fields to {word, format, legal}.
- The FSM, address counter, and handshake stay in instr_encoder.

Test Plan:
- ADD X1,X2,X3 (op0, rd1, rn2, rm3) -> imem_we on cycle N+2, addr 0, wdata 0x8B030041, wr_count=1.
- LDUR X5,[X6,#8] then CBZ X9,#-2 -> addr 1 wdata 0xF84080C5, then addr 2 wdata 0xB4FFFFC9.
- B #4 -> wdata 0x14000004; LDUR imm=256 -> err pulse, no write, address unchanged; op 13 -> err, no write.
- DEPTH=4: four legal writes -> full=1, in_ready=0; fifth in_valid held 10 cycles -> no write; clr -> full=0, next write at addr 0.
- clr asserted in WRITE cycle -> imem_we=0, wr_count=0; rst_n pulsed low mid-ENCODE -> all outputs at reset values.
- With READBACK_CHECK_EN: memory model corrupts bit 0 -> err pulse in CHECK; clean model -> no err, wr_count increments.
